// File: rtl/button_pkg.sv
// ============================================================================
// button_pkg
// Shared types and constants for the button press classifier.
// Revision: 1.0
// ============================================================================
`default_nettype none

package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    localparam int PRESS_COUNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_counter.sv
// ============================================================================
// cycle_counter
// Free-running up counter with synchronous clear (priority) and enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cycle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_press_classifier.sv
// ============================================================================
// button_press_classifier
// Classifies debounced presses as short/long, emits auto-repeat while held.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_press_classifier
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = 24,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic                     clock,
    input  logic                     reset_L,
    input  logic                     debounced,
    output logic                     short_press,
    output logic                     long_press,
    output logic                     repeat_pulse,
    output logic                     released,
    output logic                     busy,
    output logic [PRESS_COUNT_W-1:0] press_count
);

    localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clear;
    logic             cnt_en;

    // Every path back to IDLE clears cnt, so an IDLE press counts up from 0 to 1.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                cnt_en = debounced;
            end
            PRESSED: begin
                if (debounced && (cnt != LONG_LAST)) cnt_en = 1'b1;
                else                                  cnt_clear = 1'b1;
            end
            HELD: begin
                if (debounced && (cnt != REPEAT_LAST)) cnt_en = 1'b1;
                else                                    cnt_clear = 1'b1;
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase
    end

    cycle_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clock   (clock),
        .reset_L (reset_L),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .count   (cnt)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state        <= IDLE;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            released     <= 1'b0;
            press_count  <= '0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            released     <= 1'b0;
            case (state)
                IDLE: begin
                    if (debounced) state <= PRESSED;
                end
                PRESSED: begin
                    if (debounced) begin
                        if (cnt == LONG_LAST) begin
                            state       <= HELD;
                            long_press  <= 1'b1;
                            press_count <= press_count + 1'b1;
                        end
                    end else begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                        press_count <= press_count + 1'b1;
                    end
                end
                HELD: begin
                    if (debounced) begin
                        if (cnt == REPEAT_LAST) repeat_pulse <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        released <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_button_press_classifier.sv
// ============================================================================
// tb_button_press_classifier
// Randomized and directed bench against a run-length reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_press_classifier;

    localparam int L = 4;
    localparam int R = 3;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic       debounced = 1'b0;
    logic       short_press, long_press, repeat_pulse, released, busy;
    logic [7:0] press_count;

    int         n_checks = 0;
    int         n_pass   = 0;

    // Reference model: length of the current run of high samples and press total
    int         m_run = 0;
    logic [7:0] m_count = 8'd0;
    logic       e_short, e_long, e_rep, e_rel;

    always #5 clock = ~clock;

    button_press_classifier #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R)
    ) dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .debounced    (debounced),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .released     (released),
        .busy         (busy),
        .press_count  (press_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_run   = 0;
        m_count = 8'd0;
        e_short = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        e_rel   = 1'b0;
    endtask

    task automatic model_sample(input logic d);
        e_short = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        e_rel   = 1'b0;
        if (d) begin
            m_run++;
            if (m_run == L) begin
                e_long  = 1'b1;
                m_count = m_count + 8'd1;
            end else if (m_run > L && ((m_run - L) % R) == 0) begin
                e_rep = 1'b1;
            end
        end else begin
            if (m_run > 0 && m_run < L) begin
                e_short = 1'b1;
                m_count = m_count + 8'd1;
            end else if (m_run >= L) begin
                e_rel = 1'b1;
            end
            m_run = 0;
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".short"},  32'(short_press),  32'(e_short));
        check({where, ".long"},   32'(long_press),   32'(e_long));
        check({where, ".repeat"}, 32'(repeat_pulse), 32'(e_rep));
        check({where, ".rel"},    32'(released),     32'(e_rel));
        check({where, ".busy"},   32'(busy),         32'(m_run > 0));
        check({where, ".count"},  32'(press_count),  32'(m_count));
    endtask

    task automatic step(input logic d);
        debounced = d;
        @(posedge clock);
        #1;
        model_sample(d);
        check_all("step");
    endtask

    task automatic press(input int high, input int low);
        repeat (high) step(1'b1);
        repeat (low)  step(1'b0);
    endtask

    // Asynchronous reset between edges; level at release chosen by caller
    task automatic async_reset(input logic d_at_release);
        #2;
        reset_L   = 1'b0;
        debounced = d_at_release;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_all("por");
        @(negedge clock);
        reset_L = 1'b1;

        press(3, 2);              // short
        press(4, 2);              // long, no repeat
        press(10, 2);             // long with two repeats
        press(1, 1);              // glitch
        repeat (4) press(1, 1);   // alternating

        // Reset during HELD, then debounced high across release
        press(6, 0);
        async_reset(1'b1);
        press(6, 2);

        // Wrap of press_count
        async_reset(1'b0);
        repeat (255) press(1, 1);
        check("count255", 32'(press_count), 32'd255);
        press(1, 1);
        check("count_wrap", 32'(press_count), 32'd0);

        // Randomized press lengths with occasional mid-press resets
        for (int i = 0; i < 300; i++) begin
            press($urandom_range(1, 12), 0);
            if ($urandom_range(0, 29) == 0) async_reset(1'($urandom_range(0, 1)));
            else press(0, $urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: run did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
